background_scroll_ctrl: RTL and testbench

Frame-synchronous scroll controller and pixel pipeline for the background ROM. It drives the ROM's x, y and offset inputs from the VGA counters. It advances the scroll offset once per frame at the vsync edge by a programmable speed, so the offset never changes mid-frame. It then registers the returned pixel into a fixed-latency, blank-aligned stream for the display mixer.

---
 rtl/background_scroll_ctrl_pkg.sv | 26 ++
 rtl/background_scroll_ctrl_offset_accum.sv | 56 +++++
 rtl/background_scroll_ctrl.sv | 89 ++++++++
 tb/tb_background_scroll_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/background_scroll_ctrl_pkg.sv
// Shared types and widths for the background scroll controller.
// Build option: define BG_SCROLL_FRAC_EN for a 4.4 fixed-point scroll speed.
package bg_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC,
      ACTIVE,
      VBLANK
   } state_t;

   localparam int PIX_W = 12;
   localparam int X_W   = 11;
   localparam int Y_W   = 10;

`ifdef BG_SCROLL_FRAC_EN
   localparam int FRAC_W = 4;
`else
   localparam int FRAC_W = 0;
`endif

   localparam int ACC_W    = X_W + FRAC_W;
   localparam int PIPE_LAT = 2;

   localparam logic [PIX_W-1:0] BLACK = 12'h000;

endpackage

// File: rtl/background_scroll_ctrl_offset_accum.sv
// Scroll offset accumulator: pending-load capture, per-frame advance and modulo-WIDTH wrap.
module bg_offset_accum
   import bg_pkg::*;
#(
   parameter int WIDTH = 1024
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           tick,
   input  logic           scroll_en,
   input  logic [7:0]     speed,
   input  logic           load,
   input  logic [X_W-1:0] load_val,
   output logic [X_W-1:0] offset
);

   localparam logic [ACC_W:0] WRAP = (ACC_W+1)'(WIDTH) << FRAC_W;

   logic [ACC_W-1:0] acc;
   logic             pend;
   logic [X_W-1:0]   pend_val;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] acc_next;
   logic             load_now;
   logic [X_W-1:0]   load_sel;

   // A load pulse coinciding with the boundary is taken directly and beats any older capture.
   always_comb begin
      sum      = {1'b0, acc} + (ACC_W+1)'(speed);
      acc_next = (sum >= WRAP) ? ACC_W'(sum - WRAP) : ACC_W'(sum);
      load_now = load | pend;
      load_sel = load ? load_val : pend_val;
   end

   // NOTE: the synchronous reset lives inside the clocked block so every register shares one clean path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc      <= '0;
         pend     <= 1'b0;
         pend_val <= '0;
      end else if (tick) begin
         if (load_now) begin
            acc <= ACC_W'(load_sel) << FRAC_W;
         end else if (scroll_en) begin
            acc <= acc_next;
         end
         pend <= 1'b0;
      end else if (load) begin
         pend     <= 1'b1;
         pend_val <= load_val;
      end
   end

   assign offset = acc[ACC_W-1:FRAC_W];

endmodule

// File: rtl/background_scroll_ctrl.sv
// Frame-synchronous background scroll controller with a 2-stage ROM pixel pipeline.
// Fractional scroll speed is enabled by defining BG_SCROLL_FRAC_EN (see bg_pkg).
module background_scroll_ctrl
   import bg_pkg::*;
#(
   parameter int WIDTH  = 1024,
   parameter int HEIGHT = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [10:0]      hcount,
   input  logic [9:0]       vcount,
   input  logic             vsync,
   input  logic             blank,
   input  logic             scroll_en,
   input  logic [7:0]       speed,
   input  logic             load,
   input  logic [10:0]      load_val,
   output logic [10:0]      rom_x,
   output logic [9:0]       rom_y,
   output logic [10:0]      rom_offset,
   input  logic [11:0]      rom_pixel,
   output logic [11:0]      pixel_out,
   output logic             pixel_valid,
   output logic             frame_tick
);

   state_t         state;
   logic           vsync_q;
   logic           blank_q;
   logic           rise;
   logic           tick;
   logic           gate;
   logic [X_W-1:0] acc_offset;

   // Boundaries are only accepted outside VBLANK, so a long vsync gives one tick.
   always_comb begin
      rise = vsync & ~vsync_q;
      tick = rise && ((state == ACTIVE) || (state == WAIT_SYNC));
      gate = blank_q || (int'(rom_y) >= HEIGHT) || (state == WAIT_SYNC);
   end

   bg_offset_accum #(
      .WIDTH(WIDTH)
   ) u_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .scroll_en(scroll_en),
      .speed    (speed),
      .load     (load),
      .load_val (load_val),
      .offset   (acc_offset)
   );

   // NOTE: every register here is assigned with <= so all stages see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= WAIT_SYNC;
         vsync_q     <= 1'b0;
         frame_tick  <= 1'b0;
         rom_offset  <= '0;
         rom_x       <= '0;
         rom_y       <= '0;
         blank_q     <= 1'b1;
         pixel_out   <= BLACK;
         pixel_valid <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         frame_tick <= tick;
         rom_offset <= acc_offset;

         rom_x   <= hcount;
         rom_y   <= vcount;
         blank_q <= blank;

         pixel_out   <= gate ? BLACK : rom_pixel;
         pixel_valid <= ~gate;

         case (state)
            WAIT_SYNC: if (rise) state <= VBLANK;
            ACTIVE:    if (rise) state <= VBLANK;
            VBLANK:    if ((vcount == '0) && !vsync) state <= ACTIVE;
            default:   state <= WAIT_SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_background_scroll_ctrl.sv
// Directed self-checking bench for background_scroll_ctrl (default and BG_SCROLL_FRAC_EN builds).
module tb_background_scroll_ctrl;
   import bg_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        vsync;
   logic        blank;
   logic        scroll_en;
   logic [7:0]  speed;
   logic        load;
   logic [10:0] load_val;
   logic [10:0] rom_x;
   logic [9:0]  rom_y;
   logic [10:0] rom_offset;
   logic [11:0] rom_pixel;
   logic [11:0] pixel_out;
   logic        pixel_valid;
   logic        frame_tick;

   int checks   = 0;
   int failures = 0;
   int ticks;

   always #5 clk = ~clk;

   // Combinational ROM stub keyed on rom_x so address wiring is exercised too.
   assign rom_pixel = (rom_x == 11'd37) ? 12'h7CF : 12'h123;

   background_scroll_ctrl #(
      .WIDTH (1024),
      .HEIGHT(512)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hcount     (hcount),
      .vcount     (vcount),
      .vsync      (vsync),
      .blank      (blank),
      .scroll_en  (scroll_en),
      .speed      (speed),
      .load       (load),
      .load_val   (load_val),
      .rom_x      (rom_x),
      .rom_y      (rom_y),
      .rom_offset (rom_offset),
      .rom_pixel  (rom_pixel),
      .pixel_out  (pixel_out),
      .pixel_valid(pixel_valid),
      .frame_tick (frame_tick)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Integer pixel step expressed in the speed encoding of the current build.
   function automatic logic [7:0] spd(input int px);
      return 8'(px << FRAC_W);
   endfunction

   task automatic pulse_load(input logic [10:0] v);
      load     = 1'b1;
      load_val = v;
      cyc();
      load = 1'b0;
   endtask

   // Enter ACTIVE, then raise vsync for 'hold' cycles (optionally with a load on the first), counting ticks.
   task automatic do_frame(input int hold, input logic with_load, input logic [10:0] lv, output int n);
      vsync  = 1'b0;
      vcount = 10'd0;
      cyc();
      vcount = 10'd100;
      cyc();
      n        = 0;
      vsync    = 1'b1;
      load     = with_load;
      load_val = lv;
      for (int i = 0; i < hold; i++) begin
         cyc();
         load = 1'b0;
         n += int'(frame_tick);
      end
      vsync = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n += int'(frame_tick);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      hcount    = 11'd0;
      vcount    = 10'd40;
      vsync     = 1'b0;
      blank     = 1'b0;
      scroll_en = 1'b1;
      speed     = spd(3);
      load      = 1'b0;
      load_val  = 11'd0;
      cyc();
      cyc();

      check("rst_rom_offset", 32'(rom_offset), 32'd0);
      check("rst_rom_x", 32'(rom_x), 32'd0);
      check("rst_pixel_out", 32'(pixel_out), 32'h000);
      check("rst_frame_tick", 32'(frame_tick), 32'd0);
      rst_n = 1'b1;
      cyc();
      cyc();
      cyc();
      check("waitsync_pixel_valid", 32'(pixel_valid), 32'd0);
      check("waitsync_pixel_out", 32'(pixel_out), 32'h000);

      // First boundary, exact tick and offset timing.
      vcount = 10'd100;
      vsync  = 1'b1;
      cyc();
      check("t1_tick_high", 32'(frame_tick), 32'd1);
      check("t1_offset_not_yet", 32'(rom_offset), 32'd0);
      vsync = 1'b0;
      cyc();
      check("t1_tick_low", 32'(frame_tick), 32'd0);
      check("t1_offset_3", 32'(rom_offset), 32'd3);
      cyc();

      do_frame(5, 1'b0, 11'd0, ticks);
      check("held_vsync_ticks", 32'(ticks), 32'd1);
      check("held_vsync_offset", 32'(rom_offset), 32'd6);

      do_frame(1, 1'b1, 11'd1022, ticks);
      check("load_1022", 32'(rom_offset), 32'd1022);
      speed = spd(5);
      do_frame(1, 1'b0, 11'd0, ticks);
      check("wrap_1022_plus5", 32'(rom_offset), 32'd3);

      // Mid-frame loads stay pending; last one wins, load beats advance.
      vcount = 10'd0;
      cyc();
      vcount = 10'd100;
      cyc();
      pulse_load(11'd50);
      cyc();
      pulse_load(11'd100);
      cyc();
      cyc();
      check("pending_offset_stable", 32'(rom_offset), 32'd3);
      do_frame(1, 1'b0, 11'd0, ticks);
      check("pending_load_100", 32'(rom_offset), 32'd100);
      do_frame(1, 1'b0, 11'd0, ticks);
      check("after_load_plus5", 32'(rom_offset), 32'd105);

      do_frame(1, 1'b1, 11'd200, ticks);
      check("load_at_boundary", 32'(rom_offset), 32'd200);
      scroll_en = 1'b0;
      do_frame(1, 1'b0, 11'd0, ticks);
      check("scroll_disabled_hold", 32'(rom_offset), 32'd200);
      scroll_en = 1'b1;

`ifdef BG_SCROLL_FRAC_EN
      do_frame(1, 1'b1, 11'd0, ticks);
      check("frac_load_0", 32'(rom_offset), 32'd0);
      speed = 8'h08;
      do_frame(1, 1'b0, 11'd0, ticks);
      check("frac_f1", 32'(rom_offset), 32'd0);
      do_frame(1, 1'b0, 11'd0, ticks);
      check("frac_f2", 32'(rom_offset), 32'd1);
      do_frame(1, 1'b0, 11'd0, ticks);
      check("frac_f3", 32'(rom_offset), 32'd1);
      do_frame(1, 1'b0, 11'd0, ticks);
      check("frac_f4", 32'(rom_offset), 32'd2);
      speed = spd(5);
`endif

      // Pixel pipeline: 2-clock latency and blanking/row gating.
      hcount = 11'd0;
      vcount = 10'd40;
      blank  = 1'b1;
      cyc();
      cyc();
      hcount = 11'd37;
      blank  = 1'b0;
      cyc();
      check("pix_rom_x", 32'(rom_x), 32'd37);
      check("pix_rom_y", 32'(rom_y), 32'd40);
      check("pix_valid_lat1", 32'(pixel_valid), 32'd0);
      cyc();
      check("pix_out_lat2", 32'(pixel_out), 32'h7CF);
      check("pix_valid_lat2", 32'(pixel_valid), 32'd1);
      blank = 1'b1;
      cyc();
      cyc();
      check("pix_blank_out", 32'(pixel_out), 32'h000);
      check("pix_blank_valid", 32'(pixel_valid), 32'd0);
      blank  = 1'b0;
      vcount = 10'd600;
      cyc();
      cyc();
      check("pix_row600_out", 32'(pixel_out), 32'h000);
      check("pix_row600_valid", 32'(pixel_valid), 32'd0);
      vcount = 10'd511;
      cyc();
      cyc();
      check("pix_row511_out", 32'(pixel_out), 32'h7CF);
      check("pix_row511_valid", 32'(pixel_valid), 32'd1);
      hcount = 11'd0;

      // Reset mid-ACTIVE discards offset and pending load.
      do_frame(1, 1'b1, 11'd500, ticks);
      check("pre_reset_offset_500", 32'(rom_offset), 32'd500);
      vcount = 10'd0;
      cyc();
      vcount = 10'd100;
      cyc();
      pulse_load(11'd77);
      rst_n = 1'b0;
      cyc();
      check("midrst_offset", 32'(rom_offset), 32'd0);
      check("midrst_rom_x", 32'(rom_x), 32'd0);
      check("midrst_rom_y", 32'(rom_y), 32'd0);
      check("midrst_pixel_out", 32'(pixel_out), 32'h000);
      check("midrst_pixel_valid", 32'(pixel_valid), 32'd0);
      check("midrst_frame_tick", 32'(frame_tick), 32'd0);
      rst_n = 1'b1;
      do_frame(1, 1'b0, 11'd0, ticks);
      check("post_rst_ticks", 32'(ticks), 32'd1);
      check("post_rst_offset_speed", 32'(rom_offset), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
